// File: rtl/start_code_scanner.sv
// Start-code scanner: byte-aligns the bitstream, then skips bytes until the lookahead shows 0x000001.
// Optional macro SCAN_CONSUME_CODE_EN: also flush the 32-bit start code before reporting found.
module start_code_scanner #(
    parameter int MAX_SKIP = 4096,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      show_bfr,
    input  logic [31:0]      incnt,
    input  logic             fb_done,
    output logic [31:0]      fb_N,
    output logic             fb_valid,
    output logic             busy,
    output logic             found,
    output logic [7:0]       start_code,
    output logic [CNT_W-1:0] bytes_skipped,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SKIP);

    typedef enum logic [2:0] {
        IDLE, ALIGN, W_ALIGN, CHECK, W_SKIP, DONE
`ifdef SCAN_CONSUME_CODE_EN
        , W_CONS
`endif
    } state_t;

    state_t      state, state_n;
    logic [31:0] fb_n_q, req_n;
    logic        req, skip_inc, load_code, clr_cnt;
    logic        match;
    logic        unused_incnt;

    // Only the low three bits matter; this also covers negative counts.
    assign unused_incnt = ^incnt[31:3];
    assign match        = (show_bfr[31:8] == 24'h000001);

    always_comb begin
        state_n   = state;
        req       = 1'b0;
        req_n     = 32'd0;
        skip_inc  = 1'b0;
        load_code = 1'b0;
        clr_cnt   = 1'b0;
        found     = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_cnt = 1'b1;
                    state_n = ALIGN;
                end
            end
            ALIGN: begin
                if (incnt[2:0] != 3'd0) begin
                    req     = 1'b1;
                    req_n   = {29'd0, incnt[2:0]};
                    state_n = W_ALIGN;
                end else begin
                    state_n = CHECK;
                end
            end
            W_ALIGN: if (fb_done) state_n = CHECK;
            CHECK: begin
                if (match) begin
                    load_code = 1'b1;
`ifdef SCAN_CONSUME_CODE_EN
                    req       = 1'b1;
                    req_n     = 32'd32;
                    state_n   = W_CONS;
`else
                    state_n   = DONE;
`endif
                end else if (bytes_skipped == MAX_CNT) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end else begin
                    req      = 1'b1;
                    req_n    = 32'd8;
                    skip_inc = 1'b1;
                    state_n  = W_SKIP;
                end
            end
            W_SKIP: if (fb_done) state_n = CHECK;
`ifdef SCAN_CONSUME_CODE_EN
            W_CONS: if (fb_done) state_n = DONE;
`endif
            DONE: begin
                found   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // fb_N shows the new length during the request cycle and holds it afterwards.
    assign fb_valid = req;
    assign fb_N     = req ? req_n : fb_n_q;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            fb_n_q        <= 32'd0;
            start_code    <= 8'd0;
            bytes_skipped <= '0;
        end else begin
            state <= state_n;
            if (req)       fb_n_q     <= req_n;
            if (load_code) start_code <= show_bfr[7:0];
            if (clr_cnt)
                bytes_skipped <= '0;
            else if (skip_inc && bytes_skipped != MAX_CNT)
                bytes_skipped <= bytes_skipped + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_start_code_scanner.sv
// Bench for start_code_scanner: refill-stage model plus a scoreboard of expected found/err events.
module tb_start_code_scanner;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      show_bfr = 32'd0;
    logic [31:0]      incnt = 32'd0;
    logic             fb_done = 1'b0;
    logic [31:0]      fb_N;
    logic             fb_valid, busy, found, err;
    logic [7:0]       start_code;
    logic [CNT_W-1:0] bytes_skipped;

    start_code_scanner #(.MAX_SKIP(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .show_bfr(show_bfr), .incnt(incnt),
        .fb_done(fb_done), .fb_N(fb_N), .fb_valid(fb_valid), .busy(busy),
        .found(found), .start_code(start_code), .bytes_skipped(bytes_skipped), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        int         skip;
        int         lat;
        int         t0;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] word_q[$];
    int          req_q[$];
    int          exp_req[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          lat = 1;
    int          cd = 0;
    bit          inject = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Refill stage: one request at a time, answers after `lat` cycles with the next queued word.
    initial forever begin
        @(negedge clk);
        fb_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                if (word_q.size() != 0) show_bfr = word_q.pop_front();
                fb_done = 1'b1;
            end
        end else if (fb_valid && !rst) begin
            req_q.push_back(int'(fb_N));
            cd = lat;
        end else if (inject) begin
            fb_done = 1'b1;
            inject  = 1'b0;
        end
    end

    // Scoreboard: compare each found/err pulse against the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (!rst && (found || err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {30'd0, found, err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("kind_err", {31'd0, err}, {31'd0, e.is_err});
                chk("kind_found", {31'd0, found}, {31'd0, !e.is_err});
                if (!e.is_err) chk("start_code", {24'd0, start_code}, {24'd0, e.code});
                chk("bytes_skipped", bytes_skipped, e.skip);
                if (e.lat >= 0) chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic add_cons();
`ifdef SCAN_CONSUME_CODE_EN
        exp_req.push_back(32);
        word_q.push_back(32'hDEADBEEF);
`endif
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_within_bound", {31'd0, ok}, 32'd1);
    endtask

    task automatic kick(input bit is_err, input logic [7:0] code, input int skip, input int lt);
        @(negedge clk);
        start = 1'b1;
        sb.push_back('{is_err, code, skip, lt, cyc});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_case(input logic [31:0] ic, input logic [31:0] w0, input bit is_err,
                            input logic [7:0] code, input int skip, input int lt);
        incnt    = ic;
        show_bfr = w0;
        req_q.delete();
        kick(is_err, code, skip, lt);
        wait_idle();
        chk("req_count", req_q.size(), exp_req.size());
        for (int i = 0; i < exp_req.size() && i < req_q.size(); i++)
            chk("req_fb_N", req_q[i], exp_req[i]);
        exp_req.delete();
        word_q.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_fb_N", fb_N, 32'd0);
        chk("rst_fb_valid", {31'd0, fb_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_found", {31'd0, found}, 32'd0);
        chk("rst_start_code", {24'd0, start_code}, 32'd0);
        chk("rst_bytes_skipped", bytes_skipped, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
    endtask

    int aligned_lat;
    bit seen;

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

`ifdef SCAN_CONSUME_CODE_EN
        aligned_lat = -1;
`else
        aligned_lat = 3;
`endif
        // Aligned stream already on a start code.
        add_cons();
        run_case(32'd32, 32'h000001B3, 1'b0, 8'hB3, 0, aligned_lat);

        // Misaligned by 5 bits.
        exp_req.push_back(5);
        word_q.push_back(32'h000001B8);
        add_cons();
        run_case(32'd29, 32'h12345678, 1'b0, 8'hB8, 0, -1);

        // One byte skipped.
        exp_req.push_back(8);
        word_q.push_back(32'h000001B5);
        add_cons();
        run_case(32'd32, 32'hFF000001, 1'b0, 8'hB5, 1, -1);

        // Negative incnt: -3 has low bits 3'b101.
        exp_req.push_back(5);
        word_q.push_back(32'h000001AF);
        add_cons();
        run_case(32'hFFFF_FFFD, 32'h0, 1'b0, 8'hAF, 0, -1);

        // Timeout after MAX_SKIP byte flushes.
        for (int i = 0; i < 4; i++) exp_req.push_back(8);
        run_case(32'd32, 32'hFFFFFFFF, 1'b1, 8'h00, 4, -1);
        chk("timeout_busy", {31'd0, busy}, 32'd0);

        // Code byte 0x00.
        add_cons();
        run_case(32'd16, 32'h00000100, 1'b0, 8'h00, 0, -1);

        // start during W_SKIP is ignored.
        lat = 4;
        incnt = 32'd32;
        show_bfr = 32'hFF000001;
        req_q.delete();
        word_q.push_back(32'h000001B5);
        add_cons();
        kick(1'b0, 8'hB5, 1, -1);
        for (int i = 0; i < 50 && req_q.size() == 0; i++) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        word_q.delete();
        exp_req.delete();

        // Spurious fb_done while idle.
        inject = 1'b1;
        repeat (4) @(negedge clk);
        chk("spurious_done_busy", {31'd0, busy}, 32'd0);

        // Reset in W_SKIP; the late fb_done must not restart anything.
        lat = 6;
        show_bfr = 32'hFF000001;
        req_q.delete();
        word_q.push_back(32'h000001B5);
        kick(1'b0, 8'hB5, 1, -1);
        for (int i = 0; i < 50 && req_q.size() == 0; i++) @(negedge clk);
        @(negedge clk);
        seen = busy;
        chk("pre_rst_busy", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_skipped", bytes_skipped, 32'd0);
        word_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/start_code_scanner.md
Name: start_code_scanner

Overview:
- Bitstream-layer stage directly downstream of the bit-buffer refill stage (flushbuffer) in the MPEG decoder.
- Implements next_start_code():
  - byte-aligns the stream by flushing incnt&7 bits;
  - flushes 8 bits at a time until the 32-bit lookahead word shows prefix 0x000001;
  - reports the start-code value byte.
- Drives the refill stage's N/in_valid request pair and consumes its lookahead word, bit count and completion pulse.

Parameters:
- MAX_SKIP, 4096: maximum byte flushes allowed before giving up with an error.
- CNT_W, 32: width of the skipped-byte counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse: begin a search; ignored unless in IDLE
- show_bfr  input  32  lookahead word from refill stage, MSB = next bit
- incnt  input  32  signed valid-bit count from refill stage
- fb_done  input  1  one-cycle pulse: requested flush and refill complete, show_bfr/incnt updated
- fb_N  output  32  flush length to refill stage
- fb_valid  output  1  one-cycle flush request strobe
- busy  output  1  high in every state except IDLE
- found  output  1  one-cycle pulse: start code located
- start_code  output  8  code byte following prefix; held until next found
- bytes_skipped  output  CNT_W  whole bytes flushed during the last search; excludes the alignment flush
- err  output  1  one-cycle pulse: MAX_SKIP exceeded

Behaviour:
- Reset: synchronous, takes priority over all other inputs, including mid-search.
  - State IDLE.
  - fb_N=0, fb_valid=0, busy=0, found=0, start_code=0, bytes_skipped=0, err=0.
  - An outstanding fb_done after reset is ignored.
- States:
  - IDLE: start=1 -> ALIGN and clear bytes_skipped.
  - ALIGN:
    - r = incnt[2:0].
    - r!=0 -> fb_N=r, fb_valid=1 for one cycle, go W_ALIGN.
    - r==0 -> CHECK with no request.
  - W_ALIGN: wait for fb_done -> CHECK.
  - CHECK (show_bfr valid this cycle):
    - show_bfr[31:8]==24'h000001 -> start_code<=show_bfr[7:0], go DONE.
    - Otherwise, if bytes_skipped==MAX_SKIP -> err=1 for one cycle, go IDLE.
    - Otherwise fb_N=8, fb_valid=1, bytes_skipped+=1, go W_SKIP.
  - W_SKIP: fb_done -> CHECK.
  - DONE: found=1 for one cycle, go IDLE.
- Handshake:
  - At most one outstanding request; fb_valid is never asserted while in W_ALIGN or W_SKIP.
  - fb_N holds its value until the next request.
  - fb_done in any state other than W_ALIGN/W_SKIP is ignored.
- Latency:
  - Aligned stream already showing a start code: start at cycle t -> found at t+3 (ALIGN t+1, CHECK t+2, DONE t+3).
  - Each skipped byte adds 1 cycle plus the refill stage's latency.
- Boundaries:
  - start while busy is ignored.
  - fb_done arriving in the same cycle as the request is not accepted; it is only sampled in W_*.
  - Negative incnt uses only the low 3 bits, per two's complement.
  - The bytes_skipped increment saturates at MAX_SKIP.

Optional Feature:
- SCAN_CONSUME_CODE_EN defined:
  - CHECK-match goes to W_CONS instead of DONE, issuing fb_N=32, fb_valid=1.
  - W_CONS waits for fb_done, then DONE.
  - found therefore means the code has been removed and show_bfr starts at the payload.
  - The consume flush is not counted in bytes_skipped.
- SCAN_CONSUME_CODE_EN undefined:
  - The buffer is left positioned on the 32-bit start code.
  - W_CONS does not exist.

Test Plan:
- Aligned match: rst, then start with incnt=32, show_bfr=32'h000001B3 -> no fb_valid, found at t+3, start_code=8'hB3, bytes_skipped=0.
- Misaligned: incnt=29 -> fb_valid with fb_N=5; after fb_done, show_bfr=32'h000001B8 -> found, start_code=8'hB8, bytes_skipped=0.
- Skip: show_bfr sequence 32'hFF000001, then 32'h000001B5 -> exactly one fb_N=8 request, found, start_code=8'hB5, bytes_skipped=1.
- Timeout: MAX_SKIP=4, show_bfr fixed at 32'hFFFFFFFF -> four fb_N=8 requests, then err pulse, busy=0, found never asserted.
- Robustness: start while in W_SKIP is ignored; spurious fb_done in IDLE is ignored; rst asserted in W_SKIP -> next cycle all outputs at reset values, and a later fb_done causes no transition.
- With SCAN_CONSUME_CODE_EN: match 32'h00000100 -> fb_N=32 request, found only after the matching fb_done, start_code=8'h00.
